// File: rtl/irq_controller.sv
// Memory-mapped fixed-priority interrupt controller with PEND/MASK/ID/CTRL registers
// and a request/acknowledge/EOI handshake. Define IRQ_EDGE_DETECT_EN for rising-edge sources.
module irq_controller #(
   parameter int               BITS  = 32,
   parameter int               N_SRC = 4,
   parameter logic [BITS-1:0]  BASE  = 32'hF0000100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [BITS-1:0]   memAddr,
   input  logic [BITS-1:0]   dataBusIn,
   output logic [BITS-1:0]   dataBusOut,
   input  logic [N_SRC-1:0]  irqSrc,
   output logic              irqReq,
   input  logic              irqAck,
   output logic [3:0]        irqId
);

   localparam logic [BITS-1:0] ADDR_PEND = BASE;
   localparam logic [BITS-1:0] ADDR_MASK = BASE + BITS'(4);
   localparam logic [BITS-1:0] ADDR_ID   = BASE + BITS'(8);
   localparam logic [BITS-1:0] ADDR_CTRL = BASE + BITS'(12);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   pend_q, pend_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic               gie_q, gie_d;
   logic [3:0]         cur_id_q, cur_id_d;
   logic               irq_req_q, irq_req_d;

   logic               sel_pend, sel_mask, sel_id, sel_ctrl;
   logic               wr_pend, wr_mask, wr_id, wr_ctrl;
   logic               rd_en;
   logic [N_SRC-1:0]   set_cond;
   logic [N_SRC-1:0]   clr;
   logic [N_SRC-1:0]   cur_onehot;
   logic [N_SRC-1:0]   eligible;
   logic               has_eligible;
   logic               cur_valid;
   logic               ack_fire;
   logic               in_service;
   logic [3:0]         winner;
   logic               found;
   logic [BITS-1:0]    rd_data;
   logic               unused_data_bits;

   assign sel_pend = (memAddr == ADDR_PEND);
   assign sel_mask = (memAddr == ADDR_MASK);
   assign sel_id   = (memAddr == ADDR_ID);
   assign sel_ctrl = (memAddr == ADDR_CTRL);

   assign wr_pend = we & sel_pend;
   assign wr_mask = we & sel_mask;
   assign wr_id   = we & sel_id;
   assign wr_ctrl = we & sel_ctrl;
   assign rd_en   = re & ~we;

   assign unused_data_bits = ^dataBusIn[BITS-1:N_SRC];

`ifdef IRQ_EDGE_DETECT_EN
   logic [N_SRC-1:0]   src_q, src_d;

   always_comb begin
      src_d = irqSrc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q <= '0;
      end else begin
         src_q <= src_d;
      end
   end

   assign set_cond = irqSrc & ~src_q;
`else
   assign set_cond = irqSrc;
`endif

   assign cur_onehot   = N_SRC'(1) << cur_id_q;
   assign ack_fire     = (state_q == REQ) && irqAck;
   assign eligible     = pend_q & mask_q & {N_SRC{gie_q}};
   assign has_eligible = |eligible;
   assign cur_valid    = |(eligible & cur_onehot);
   assign in_service   = (state_q == SERVICE);

   // A newly arriving condition wins over a clear landing on the same bit.
   always_comb begin
      clr    = (wr_pend ? dataBusIn[N_SRC-1:0] : '0) | (ack_fire ? cur_onehot : '0);
      pend_d = (pend_q & ~clr) | set_cond;
      mask_d = wr_mask ? dataBusIn[N_SRC-1:0] : mask_q;
      gie_d  = wr_ctrl ? dataBusIn[0] : gie_q;
   end

   always_comb begin
      winner = 4'd0;
      found  = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (!found && eligible[i]) begin
            winner = 4'(i);
            found  = 1'b1;
         end
      end
   end

   // curId is frozen from request to EOI; a higher-priority arrival never preempts.
   always_comb begin
      state_d   = state_q;
      irq_req_d = irq_req_q;
      cur_id_d  = cur_id_q;
      case (state_q)
         IDLE: begin
            irq_req_d = 1'b0;
            if (has_eligible) begin
               cur_id_d  = winner;
               irq_req_d = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (irqAck) begin
               irq_req_d = 1'b0;
               state_d   = SERVICE;
            end else if (!cur_valid) begin
               irq_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         SERVICE: begin
            irq_req_d = 1'b0;
            if (wr_id) begin
               state_d = IDLE;
            end
         end
         default: begin
            irq_req_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pend_q    <= '0;
         mask_q    <= '0;
         gie_q     <= 1'b0;
         cur_id_q  <= 4'd0;
         irq_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         gie_q     <= gie_d;
         cur_id_q  <= cur_id_d;
         irq_req_q <= irq_req_d;
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         if (sel_pend) begin
            rd_data = BITS'(pend_q);
         end else if (sel_mask) begin
            rd_data = BITS'(mask_q);
         end else if (sel_id) begin
            rd_data[31]  = in_service;
            rd_data[3:0] = cur_id_q;
         end else if (sel_ctrl) begin
            rd_data[0] = gie_q;
         end
      end
   end

   assign dataBusOut = rd_data;
   assign irqReq     = irq_req_q;
   assign irqId      = cur_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller; expectations follow IRQ_EDGE_DETECT_EN when defined.
module tb_irq_controller;

   localparam logic [31:0] A_PEND = 32'hF0000100;
   localparam logic [31:0] A_MASK = 32'hF0000104;
   localparam logic [31:0] A_ID   = 32'hF0000108;
   localparam logic [31:0] A_CTRL = 32'hF000010C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] memAddr = '0;
   logic [31:0] dataBusIn = '0;
   logic [31:0] dataBusOut;
   logic [3:0]  irqSrc = '0;
   logic        irqReq;
   logic        irqAck = 1'b0;
   logic [3:0]  irqId;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;

   irq_controller #(.BITS(32), .N_SRC(4), .BASE(32'hF0000100)) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .re         (re),
      .memAddr    (memAddr),
      .dataBusIn  (dataBusIn),
      .dataBusOut (dataBusOut),
      .irqSrc     (irqSrc),
      .irqReq     (irqReq),
      .irqAck     (irqAck),
      .irqId      (irqId)
   );

   always #5 clk = ~clk;

   // All helpers are entered and left on a falling edge.
   task tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task bus_write(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1;
      memAddr = a;
      dataBusIn = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task bus_read(input logic [31:0] a, output logic [31:0] d);
      re = 1'b1;
      memAddr = a;
      #1;
      d = dataBusOut;
      re = 1'b0;
      #1;
   endtask

   task pulse_src(input logic [3:0] v);
      irqSrc = v;
      @(negedge clk);
      irqSrc = 4'b0000;
   endtask

   task do_ack();
      irqAck = 1'b1;
      @(negedge clk);
      irqAck = 1'b0;
   endtask

   task test_reset();
      tick(3);
      reset = 1'b0;
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got=%b exp=0", irqReq); end
      checks++; if (irqId !== 4'd0) begin errors++; $display("[TB] FAIL reset_id got=%0d exp=0", irqId); end
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_pend got=%h exp=0", rd); end
      bus_read(A_MASK, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_mask got=%h exp=0", rd); end
      bus_read(A_CTRL, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl got=%h exp=0", rd); end
      re = 1'b0;
      memAddr = A_ID;
      #1;
      checks++; if (dataBusOut !== 32'h0) begin errors++; $display("[TB] FAIL unselected_read got=%h exp=0", dataBusOut); end
      tick(1);
   endtask

   task test_single();
      bus_write(A_MASK, 32'h0000000F);
      bus_write(A_CTRL, 32'h00000001);
      pulse_src(4'b0100);
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL single_early got=%b exp=0", irqReq); end
      tick(1);
      checks++; if (irqReq !== 1'b1) begin errors++; $display("[TB] FAIL single_req got=%b exp=1", irqReq); end
      checks++; if (irqId !== 4'd2) begin errors++; $display("[TB] FAIL single_id got=%0d exp=2", irqId); end
      bus_read(A_ID, rd);
      checks++; if (rd !== 32'h00000002) begin errors++; $display("[TB] FAIL single_idreg got=%h exp=00000002", rd); end
      do_ack();
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL single_ackdrop got=%b exp=0", irqReq); end
      bus_read(A_ID, rd);
      checks++; if (rd !== 32'h80000002) begin errors++; $display("[TB] FAIL single_insvc got=%h exp=80000002", rd); end
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL single_pendclr got=%h exp=0", rd); end
      bus_write(A_ID, 32'h0);
      bus_read(A_ID, rd);
      checks++; if (rd !== 32'h00000002) begin errors++; $display("[TB] FAIL single_eoi got=%h exp=00000002", rd); end
   endtask

   task test_priority();
      pulse_src(4'b1010);
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd1) begin errors++; $display("[TB] FAIL prio_first req=%b id=%0d exp req=1 id=1", irqReq, irqId); end
      do_ack();
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h8) begin errors++; $display("[TB] FAIL prio_pend got=%h exp=8", rd); end
      bus_write(A_ID, 32'h0);
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL prio_eoi_gap got=%b exp=0", irqReq); end
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd3) begin errors++; $display("[TB] FAIL prio_second req=%b id=%0d exp req=1 id=3", irqReq, irqId); end
      do_ack();
      bus_write(A_ID, 32'h0);
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL prio_pend_end got=%h exp=0", rd); end
   endtask

   task test_gie_retract();
      pulse_src(4'b0001);
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd0) begin errors++; $display("[TB] FAIL gie_req req=%b id=%0d exp req=1 id=0", irqReq, irqId); end
      bus_write(A_CTRL, 32'h0);
      tick(1);
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL gie_retract got=%b exp=0", irqReq); end
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL gie_pend_kept got=%h exp=1", rd); end
      bus_read(A_ID, rd);
      checks++; if (rd[31] !== 1'b0) begin errors++; $display("[TB] FAIL gie_not_insvc got=%b exp=0", rd[31]); end
      bus_write(A_CTRL, 32'h1);
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd0) begin errors++; $display("[TB] FAIL gie_rereq req=%b id=%0d exp req=1 id=0", irqReq, irqId); end
      do_ack();
      bus_write(A_ID, 32'h0);
   endtask

   task test_no_preempt();
      pulse_src(4'b0001);
      tick(1);
      do_ack();
      pulse_src(4'b1000);
      tick(2);
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL svc_no_req got=%b exp=0", irqReq); end
      bus_read(A_ID, rd);
      checks++; if (rd !== 32'h80000000) begin errors++; $display("[TB] FAIL svc_id got=%h exp=80000000", rd); end
      bus_write(A_ID, 32'h0);
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL svc_eoi_gap got=%b exp=0", irqReq); end
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd3) begin errors++; $display("[TB] FAIL svc_after_eoi req=%b id=%0d exp req=1 id=3", irqReq, irqId); end
      pulse_src(4'b0001);
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd3) begin errors++; $display("[TB] FAIL req_no_preempt req=%b id=%0d exp req=1 id=3", irqReq, irqId); end
      do_ack();
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL preempt_pend got=%h exp=1", rd); end
      bus_write(A_ID, 32'h0);
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd0) begin errors++; $display("[TB] FAIL preempt_late req=%b id=%0d exp req=1 id=0", irqReq, irqId); end
      do_ack();
      bus_write(A_ID, 32'h0);
   endtask

   task test_set_clr();
      bus_write(A_CTRL, 32'h0);
      irqSrc = 4'b0100;
      we = 1'b1;
      memAddr = A_PEND;
      dataBusIn = 32'h4;
      @(negedge clk);
      we = 1'b0;
      irqSrc = 4'b0000;
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h4) begin errors++; $display("[TB] FAIL setclr_same got=%h exp=4", rd); end
      bus_write(A_PEND, 32'hFFFFFFFF);
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL w1c got=%h exp=0", rd); end
      bus_write(A_MASK, 32'hFFFFFFF0);
      bus_read(A_MASK, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mask_oor got=%h exp=0", rd); end
      bus_write(A_MASK, 32'h0000000F);
      bus_write(A_CTRL, 32'hFFFFFFFF);
      bus_read(A_CTRL, rd);
      checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL ctrl_bits got=%h exp=1", rd); end
   endtask

   task test_level_edge();
      logic        exp_rereq;
      logic [31:0] exp_pend;
`ifdef IRQ_EDGE_DETECT_EN
      exp_rereq = 1'b0;
      exp_pend  = 32'h0;
`else
      exp_rereq = 1'b1;
      exp_pend  = 32'h1;
`endif
      irqSrc = 4'b0001;
      tick(2);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd0) begin errors++; $display("[TB] FAIL hold_req req=%b id=%0d exp req=1 id=0", irqReq, irqId); end
      do_ack();
      tick(7);
      irqSrc = 4'b0000;
      bus_read(A_PEND, rd);
      checks++; if (rd !== exp_pend) begin errors++; $display("[TB] FAIL hold_pend got=%h exp=%h", rd, exp_pend); end
      bus_write(A_ID, 32'h0);
      tick(1);
      checks++; if (irqReq !== exp_rereq) begin errors++; $display("[TB] FAIL hold_rereq got=%b exp=%b", irqReq, exp_rereq); end
      if (exp_rereq) begin
         checks++; if (irqId !== 4'd0) begin errors++; $display("[TB] FAIL hold_rereq_id got=%0d exp=0", irqId); end
      end
      do_ack();
      bus_write(A_ID, 32'h0);
      tick(1);
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL hold_quiet got=%b exp=0", irqReq); end
      bus_read(A_PEND, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL hold_pend_end got=%h exp=0", rd); end
   endtask

   task test_reset_mid();
      pulse_src(4'b0100);
      tick(1);
      checks++; if (irqReq !== 1'b1 || irqId !== 4'd2) begin errors++; $display("[TB] FAIL mid_req req=%b id=%0d exp req=1 id=2", irqReq, irqId); end
      reset = 1'b1;
      tick(1);
      checks++; if (irqReq !== 1'b0 || irqId !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset req=%b id=%0d exp req=0 id=0", irqReq, irqId); end
      reset = 1'b0;
      bus_read(A_MASK, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mid_mask got=%h exp=0", rd); end
      bus_read(A_CTRL, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mid_ctrl got=%h exp=0", rd); end
      tick(2);
      checks++; if (irqReq !== 1'b0) begin errors++; $display("[TB] FAIL mid_quiet got=%b exp=0", irqReq); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_priority();
      test_gie_retract();
      test_no_preempt();
      test_set_clr();
      test_level_edge();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
